// File: rtl/channel_group_acc.sv
`default_nettype none
// ============================================================================
// channel_group_acc : accumulates adder-tree partial sums across input-channel
//                     groups and emits one final per-pixel sum on the last group
// Rev 1.0
// ============================================================================
module channel_group_acc #(
    parameter int PICTURE_NUM = 4,
    parameter int LANE_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_WIDTH:0]           pixel_num,
    input  logic [7:0]                    group_num,
    input  logic                          data_in_valid,
    input  logic [PICTURE_NUM*LANE_W-1:0] data_in,
    output logic                          data_out_valid,
    output logic [PICTURE_NUM*LANE_W-1:0] data_out,
    output logic                          busy,
    output logic                          done
);
    localparam int DATA_W = PICTURE_NUM * LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   pix_last;
    logic [7:0]            grp_last;
    logic [ADDR_WIDTH-1:0] pix_cnt;
    logic [7:0]            grp_cnt;
    logic [1:0]            flush_cnt;
    logic                  accept;
    logic                  pix_wrap;
    logic                  grp_wrap;
    logic                  last_beat;
    logic                  flush_end;

    logic                  s1_valid;
    logic [DATA_W-1:0]     s1_data;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  s1_first;
    logic                  s1_last;
    logic                  s2_valid;
    logic [DATA_W-1:0]     s2_data;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic                  s2_first;
    logic                  s2_last;
    logic [DATA_W-1:0]     rdata;
    logic [DATA_W-1:0]     sum;
    logic [DATA_W-1:0]     mem [DEPTH];

    always_comb begin
        accept     = (state == RUN) && data_in_valid;
        pix_wrap   = ({1'b0, pix_cnt} == pix_last);
        grp_wrap   = (grp_cnt == grp_last);
        last_beat  = accept && pix_wrap && grp_wrap;
        // Flush spans the two pipeline stages plus the output register, so done
        // lands in the cycle right after the last output beat.
        flush_end  = (state == FLUSH) && (flush_cnt == 2'd2);
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_beat) state_next = FLUSH;
            FLUSH:   if (flush_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pix_last  <= '0;
            grp_last  <= '0;
            pix_cnt   <= '0;
            grp_cnt   <= '0;
            flush_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            done  <= flush_end;
            if (state == IDLE && start) begin
                pix_last <= pixel_num - (ADDR_WIDTH+1)'(1);
                grp_last <= group_num - 8'd1;
                pix_cnt  <= '0;
                grp_cnt  <= '0;
            end else if (accept) begin
                if (pix_wrap) begin
                    pix_cnt <= '0;
                    grp_cnt <= grp_wrap ? 8'd0 : grp_cnt + 8'd1;
                end else begin
                    pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
                end
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            s1_addr        <= '0;
            s1_first       <= 1'b0;
            s1_last        <= 1'b0;
            s2_valid       <= 1'b0;
            s2_data        <= '0;
            s2_addr        <= '0;
            s2_first       <= 1'b0;
            s2_last        <= 1'b0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            s1_valid       <= accept;
            s1_data        <= data_in;
            s1_addr        <= pix_cnt;
            s1_first       <= (grp_cnt == 8'd0);
            s1_last        <= grp_wrap;
            s2_valid       <= s1_valid;
            s2_data        <= s1_data;
            s2_addr        <= s1_addr;
            s2_first       <= s1_first;
            s2_last        <= s1_last;
            data_out_valid <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                data_out <= sum;
            end
        end
    end

    // Write of pixel N and read of pixel N+1 share an edge; pixel_num >= 2
    // keeps them on different addresses, so no forwarding path exists.
    always_ff @(posedge clk) begin
        rdata <= mem[s1_addr];
        if (s2_valid && !s2_last) begin
            mem[s2_addr] <= sum;
        end
    end

    for (genvar p = 0; p < PICTURE_NUM; p++) begin : g_lane
        logic [LANE_W-1:0] base;
        assign base = s2_first ? '0 : rdata[p*LANE_W +: LANE_W];
        assign sum[p*LANE_W +: LANE_W] = base + s2_data[p*LANE_W +: LANE_W];
    end

endmodule
`default_nettype wire
